operand2_fetch: RTL and testbench



---
 rtl/operand2_fetch_pkg.sv | 53 +++++
 rtl/operand2_decode.sv | 56 +++++
 rtl/operand2_fetch.sv | 140 ++++++++++++++
 tb/tb_operand2_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand2_fetch_pkg.sv
// Shared definitions for the operand-2 front end: barrel_sel codes, FSM states, instruction field positions.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package operand2_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  // Bit positions inside a data-processing instruction word
  localparam int I_BIT          = 25;
  localparam int RM_LSB         = 0;
  localparam int RS_LSB         = 8;
  localparam int SHIFT_IMM_LSB  = 7;
  localparam int SHIFT_IMM_W    = 5;
  localparam int ROT_IMM_LSB    = 8;
  localparam int ROT_IMM_W      = 4;
  localparam int IMM8_LSB       = 0;
  localparam int SHIFT_TYPE_LSB = 5;
  localparam int REG_SHIFT_BIT  = 4;
  localparam int OP2_W          = 12;

  typedef enum logic [3:0] {
    LSLIMM = 4'b0000,
    LSLREG = 4'b0001,
    LSRIMM = 4'b0010,
    LSRREG = 4'b0011,
    ASRIMM = 4'b0100,
    ASRREG = 4'b0101,
    RORIMM = 4'b0110,
    RORREG = 4'b0111
  } barrel_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RM_REQ = 3'd1,
    ST_RS_REQ = 3'd2,
    ST_RS_CAP = 3'd3,
    ST_RM_CAP = 3'd4,
    ST_OUT    = 3'd5
  } state_e;

  // Only the I bit and the 12-bit shifter-operand field matter to this block
  typedef struct packed {
    logic             imm;
    logic [OP2_W-1:0] op2;
  } op2_instr_t;

  // 8-bit immediates rotate right by twice the 4-bit rotate field
  function automatic logic [DATA_W-1:0] rotate_amount(input logic [ROT_IMM_W-1:0] rot);
    return {{(DATA_W-ROT_IMM_W-1){1'b0}}, rot, 1'b0};
  endfunction

endpackage

// File: rtl/operand2_decode.sv
// Combinational decode of the shifter-operand field into barrel_sel, immediate operands and register addresses.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow the input field directly.
//
// Ports:
//   fields        in  : I bit and shifter-operand field of the instruction
//   barrel_sel    out : shift-mode encoding
//   imm_shiftee   out : zero-extended 8-bit immediate
//   imm_shifter   out : rotate amount for the immediate form (0 selects plain LSL #0)
//   shift_imm_amt out : zero-extended 5-bit shift_imm for the register/immediate-shift form
//   rm_addr       out : Rm register address
//   rs_addr       out : Rs register address
//   is_imm        out : immediate form
//   is_reg_shift  out : register form with shift amount taken from Rs
module operand2_decode
  import operand2_fetch_pkg::*;
(
  input  logic [$bits(op2_instr_t)-1:0] fields,
  output logic [3:0]                    barrel_sel,
  output logic [DATA_W-1:0]             imm_shiftee,
  output logic [DATA_W-1:0]             imm_shifter,
  output logic [DATA_W-1:0]             shift_imm_amt,
  output logic [ADDR_W-1:0]             rm_addr,
  output logic [ADDR_W-1:0]             rs_addr,
  output logic                          is_imm,
  output logic                          is_reg_shift
);

  op2_instr_t          f;
  logic [ROT_IMM_W-1:0] rot;

  assign f   = op2_instr_t'(fields);
  assign rot = f.op2[ROT_IMM_LSB +: ROT_IMM_W];

  always_comb begin
    is_imm        = f.imm;
    is_reg_shift  = !f.imm && f.op2[REG_SHIFT_BIT];
    rm_addr       = f.op2[RM_LSB +: ADDR_W];
    rs_addr       = f.op2[RS_LSB +: ADDR_W];
    imm_shiftee   = {{(DATA_W-8){1'b0}}, f.op2[IMM8_LSB +: 8]};
    shift_imm_amt = {{(DATA_W-SHIFT_IMM_W){1'b0}}, f.op2[SHIFT_IMM_LSB +: SHIFT_IMM_W]};
    barrel_sel    = LSLIMM;
    imm_shifter   = '0;

    if (f.imm) begin
      // A zero rotate must go out as LSL #0: RORIMM with amount 0 means RRX downstream
      if (rot != '0) begin
        barrel_sel  = RORIMM;
        imm_shifter = rotate_amount(rot);
      end
    end else begin
      barrel_sel = {1'b0, f.op2[SHIFT_TYPE_LSB +: 2], f.op2[REG_SHIFT_BIT]};
    end
  end

endmodule

// File: rtl/operand2_fetch.sv
// Fetches operand 2 for a data-processing instruction: decodes the shifter operand and reads Rm/Rs via one RF port.
// Latency: accept->op_valid 1 cycle (immediate), 3 (Rm, immediate shift), 4 (Rm and Rs, register shift).
// Backpressure: one instruction in flight; instr_ready only in IDLE; bundle held in OUT until op_ready.
//
// Ports:
//   clk, reset                        : clock, async active-high reset
//   instr_valid/instr_ready/instr     : instruction input handshake
//   flush                             : abandon the in-flight operation (returns to IDLE next cycle)
//   rf_rd_en/rf_rd_addr/rf_rd_data    : synchronous register-file read port (data one cycle after strobe)
//   op_valid/op_ready                 : operand bundle handshake
//   barrel_sel/shiftee/shifter        : operand bundle to the barrel shifter
module operand2_fetch
  import operand2_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  output logic              rf_rd_en,
  output logic [3:0]        rf_rd_addr,
  input  logic [31:0]       rf_rd_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [3:0]        barrel_sel,
  output logic [31:0]       shiftee,
  output logic [31:0]       shifter
);

  state_e     state_q, state_d;
  op2_instr_t instr_fields;
  op2_instr_t instr_q;
  op2_instr_t dec_in;

  logic [3:0]        dec_barrel_sel;
  logic [DATA_W-1:0] dec_imm_shiftee;
  logic [DATA_W-1:0] dec_imm_shifter;
  logic [DATA_W-1:0] dec_shift_imm_amt;
  logic [ADDR_W-1:0] dec_rm_addr;
  logic [ADDR_W-1:0] dec_rs_addr;
  logic              dec_is_imm;
  logic              dec_is_reg_shift;

  logic accept;
  logic handshake;
  logic unused_instr_bits;

  assign instr_fields      = '{imm: instr[I_BIT], op2: instr[OP2_W-1:0]};
  assign unused_instr_bits = ^{instr[31:I_BIT+1], instr[I_BIT-1:OP2_W]};

  // In IDLE the decoder looks at the incoming word so the immediate form can
  // be loaded on the accept edge; afterwards it looks at the latched copy.
  assign dec_in = (state_q == ST_IDLE) ? instr_fields : instr_q;

  operand2_decode u_decode (
    .fields        (dec_in),
    .barrel_sel    (dec_barrel_sel),
    .imm_shiftee   (dec_imm_shiftee),
    .imm_shifter   (dec_imm_shifter),
    .shift_imm_amt (dec_shift_imm_amt),
    .rm_addr       (dec_rm_addr),
    .rs_addr       (dec_rs_addr),
    .is_imm        (dec_is_imm),
    .is_reg_shift  (dec_is_reg_shift)
  );

  assign instr_ready = (state_q == ST_IDLE) && !flush;
  assign accept      = instr_valid && instr_ready;
  assign op_valid    = (state_q == ST_OUT);
  assign handshake   = op_valid && op_ready;

  always_comb begin
    state_d    = state_q;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = dec_is_imm ? ST_OUT : ST_RM_REQ;
      end
      ST_RM_REQ: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = dec_rm_addr;
        state_d    = dec_is_reg_shift ? ST_RS_REQ : ST_RM_CAP;
      end
      ST_RS_REQ: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = dec_rs_addr;
        state_d    = ST_RS_CAP;
      end
      ST_RS_CAP: state_d = ST_OUT;
      ST_RM_CAP: state_d = ST_OUT;
      ST_OUT: begin
        if (handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A handshake in the same cycle still completes: op_valid and op_ready
    // are both high this cycle, and IDLE is where it was going anyway.
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      barrel_sel <= '0;
      shiftee    <= '0;
      shifter    <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        instr_q    <= instr_fields;
        barrel_sel <= dec_barrel_sel;
        if (dec_is_imm) begin
          shiftee <= dec_imm_shiftee;
          shifter <= dec_imm_shifter;
        end
      end

      // Read data lands the cycle after the strobe, so each capture state
      // sits one state behind the corresponding request. Flush suppresses it.
      if (!flush) begin
        case (state_q)
          ST_RM_CAP: begin
            shiftee <= rf_rd_data;
            shifter <= dec_shift_imm_amt;
          end
          ST_RS_REQ: shiftee <= rf_rd_data;
          ST_RS_CAP: shifter <= rf_rd_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand2_fetch.sv
module tb_operand2_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        flush;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  barrel_sel;
  logic [31:0] shiftee;
  logic [31:0] shifter;

  operand2_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .flush       (flush),
    .rf_rd_en    (rf_rd_en),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .barrel_sel  (barrel_sel),
    .shiftee     (shiftee),
    .shifter     (shifter)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle synchronous read; junk when not strobed
  logic [31:0] regs [16];
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= regs[rf_rd_addr];
    else          rf_rd_data <= $urandom;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] shiftee;
    logic [31:0] shifter;
    int          lat;
    int          nreads;
    logic [3:0]  rd [2];
  } exp_t;

  // Expected bundle straight from the instruction-set rules
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   rot;
    e.rd[0] = 0;
    e.rd[1] = 0;
    if (w[25]) begin
      e.shiftee = w & 32'hFF;
      rot       = int'((w >> 8) & 15);
      if (rot == 0) begin
        e.sel     = 4'd0;
        e.shifter = 0;
      end else begin
        e.sel     = 4'd6;
        e.shifter = 32'(rot * 2);
      end
      e.lat    = 1;
      e.nreads = 0;
    end else begin
      e.sel     = 4'(((w >> 5) & 3) * 2 + ((w >> 4) & 1));
      e.rd[0]   = w[3:0];
      e.shiftee = regs[w[3:0]];
      if (w[4]) begin
        e.rd[1]   = w[11:8];
        e.shifter = regs[w[11:8]];
        e.lat     = 4;
        e.nreads  = 2;
      end else begin
        e.shifter = (w >> 7) & 31;
        e.lat     = 3;
        e.nreads  = 1;
      end
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle
  task automatic run_op(input logic [31:0] w, input int hold);
    exp_t       e;
    int         cyc;
    int         nrd;
    logic [3:0] rda [2];
    int         rdc [2];
    bit         got;
    e = model(w);
    check("instr_ready_idle", instr_ready, 1);
    instr       = w;
    instr_valid = 1;
    op_ready    = 0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    instr       = $urandom;
    cyc = 1;
    nrd = 0;
    got = 0;
    while (cyc <= 8) begin
      if (rf_rd_en) begin
        if (nrd < 2) begin
          rda[nrd] = rf_rd_addr;
          rdc[nrd] = cyc;
        end
        nrd++;
      end else begin
        check("rd_addr_zero_when_idle", rf_rd_addr, 0);
      end
      if (op_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("op_valid_seen", got, 1);
    if (!got) return;
    check("latency", cyc, e.lat);
    check("read_count", nrd, e.nreads);
    for (int i = 0; i < nrd && i < 2 && i < e.nreads; i++) begin
      check("read_addr", rda[i], e.rd[i]);
      check("read_cycle", rdc[i], i + 1);
    end
    for (int h = 0; h <= hold; h++) begin
      check("barrel_sel", barrel_sel, e.sel);
      check("shiftee", shiftee, e.shiftee);
      check("shifter", shifter, e.shifter);
      check("op_valid_held", op_valid, 1);
      check("instr_ready_in_out", instr_ready, 0);
      if (h < hold) @(negedge clk);
    end
    op_ready = 1;
    @(negedge clk);
    op_ready = 0;
    check("op_valid_after_hs", op_valid, 0);
    check("instr_ready_after_hs", instr_ready, 1);
  endtask

  initial begin
    reset       = 0;
    instr_valid = 0;
    instr       = 0;
    flush       = 0;
    op_ready    = 0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    #1 reset = 1;
    @(negedge clk);
    check("rst_op_valid", op_valid, 0);
    check("rst_barrel_sel", barrel_sel, 0);
    check("rst_shiftee", shiftee, 0);
    check("rst_shifter", shifter, 0);
    check("rst_rf_rd_en", rf_rd_en, 0);
    check("rst_rf_rd_addr", rf_rd_addr, 0);
    reset = 0;
    @(negedge clk);
    check("instr_ready_after_rst", instr_ready, 1);

    // Directed vectors
    run_op(32'hE3A004FF, 0);
    run_op(32'hE3A00012, 0);
    regs[2] = 32'hDEADBEEF;
    run_op(32'hE1A01102, 0);
    regs[2] = 32'h80000000;
    regs[3] = 32'h00000121;
    run_op(32'hE1A01352, 5);

    // Flush while the Rs read is outstanding
    instr       = 32'hE1A01352;
    instr_valid = 1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    check("flush_rs_req_en", rf_rd_en, 1);
    check("flush_rs_req_addr", rf_rd_addr, 3);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    check("flush_instr_ready", instr_ready, 1);
    for (int i = 0; i < 5; i++) begin
      check("flush_no_op_valid", op_valid, 0);
      @(negedge clk);
    end

    // Flush coinciding with the output handshake
    instr       = 32'hE3A00155;
    instr_valid = 1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    check("flush_hs_op_valid", op_valid, 1);
    check("flush_hs_shifter", shifter, 2);
    op_ready = 1;
    flush    = 1;
    @(negedge clk);
    op_ready = 0;
    flush    = 0;
    #1;
    check("flush_hs_idle_op_valid", op_valid, 0);
    check("flush_hs_idle_ready", instr_ready, 1);
    @(negedge clk);

    // Async reset during RM_CAP
    instr       = 32'hE1A01102;
    instr_valid = 1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    reset = 1;
    #1;
    check("arst_op_valid", op_valid, 0);
    check("arst_barrel_sel", barrel_sel, 0);
    check("arst_shiftee", shiftee, 0);
    check("arst_shifter", shifter, 0);
    check("arst_rf_rd_en", rf_rd_en, 0);
    check("arst_rf_rd_addr", rf_rd_addr, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("arst_instr_ready", instr_ready, 1);

    // Randomized transactions against the model
    for (int t = 0; t < 60; t++) begin
      logic [31:0] w;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      w     = $urandom;
      w[25] = ($urandom_range(0, 2) == 0);
      run_op(w, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
